// File: rtl/host_key_decoder.sv
// ---------------------------------------------------------------------------
// host_key_decoder
//
// Purpose:
//   Decodes the PS/2 set-2 make/break scancode stream from the byte receiver
//   into level-held movement commands (left, right, jump) for the host
//   movement controller. An R-key press also produces a stretched game-reset
//   pulse. All outputs are registered, so consumers can sample them every
//   clock without seeing glitches.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx_data    in   [7:0] received scancode byte
//   rx_valid   in   one-cycle strobe, rx_data valid
//   rx_err     in   one-cycle strobe, receiver framing/parity error
//   left       out  left arrow held
//   right      out  right arrow held
//   jump       out  up arrow or space held
//   game_reset out  reset request, high RESET_PULSE_CYCLES cycles
//   key_event  out  one-cycle strobe when any tracked key changes state
//
// Configuration:
//   HOST_KEYS_SOCD_EN - when defined, left/right use last-pressed-wins
//   resolution while both arrows are held. Undefined: raw held flags.
// ---------------------------------------------------------------------------
module host_key_decoder #(
  parameter int TIMEOUT_CYCLES     = 1_000_000,
  parameter int RESET_PULSE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic       game_reset,
  output logic       key_event
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int PW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_CODE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [PW-1:0] pulse_cnt_q;

  logic left_held_q, left_held_d;
  logic right_held_q, right_held_d;
  logic up_held_q, up_held_d;
  logic space_held_q, space_held_d;
  logic r_held_q, r_held_d;

  logic code_done;
  logic is_ext;
  logic is_brk;
  logic left_out_d;
  logic right_out_d;
  logic flags_changed;

`ifdef HOST_KEYS_SOCD_EN
  logic last_dir_q, last_dir_d;
`endif

  // Prefix tracking, timeout and held-flag update. rx_err has priority over
  // a coincident byte; a byte has priority over a coincident timeout.
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    left_held_d  = left_held_q;
    right_held_d = right_held_q;
    up_held_d    = up_held_q;
    space_held_d = space_held_q;
    r_held_d     = r_held_q;
    code_done    = 1'b0;
    is_ext       = 1'b0;
    is_brk       = 1'b0;
`ifdef HOST_KEYS_SOCD_EN
    last_dir_d   = last_dir_q;
`endif

    if (rx_err) begin
      state_d  = WAIT_CODE;
      to_cnt_d = '0;
    end else if (rx_valid) begin
      to_cnt_d = '0;
      state_d  = WAIT_CODE;
      case (state_q)
        WAIT_CODE: begin
          if (rx_data == 8'hE0)      state_d = GOT_E0;
          else if (rx_data == 8'hF0) state_d = GOT_F0;
          else                       code_done = 1'b1;
        end
        GOT_E0: begin
          if (rx_data == 8'hF0) state_d = GOT_E0F0;
          else begin
            code_done = 1'b1;
            is_ext    = 1'b1;
          end
        end
        GOT_F0: begin
          code_done = 1'b1;
          is_brk    = 1'b1;
        end
        default: begin
          code_done = 1'b1;
          is_ext    = 1'b1;
          is_brk    = 1'b1;
        end
      endcase
    end else if (state_q != WAIT_CODE) begin
      // An abandoned prefix drops back to idle without touching held keys.
      if (to_cnt_q == TO_LAST) begin
        state_d  = WAIT_CODE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end

    // Extended and plain code spaces are disjoint: bare 6B is not left.
    if (code_done) begin
      if (is_ext) begin
        case (rx_data)
          8'h6B: begin
            left_held_d = ~is_brk;
`ifdef HOST_KEYS_SOCD_EN
            if (!is_brk) last_dir_d = 1'b0;
`endif
          end
          8'h74: begin
            right_held_d = ~is_brk;
`ifdef HOST_KEYS_SOCD_EN
            if (!is_brk) last_dir_d = 1'b1;
`endif
          end
          8'h75:   up_held_d = ~is_brk;
          default: ;
        endcase
      end else begin
        case (rx_data)
          8'h29:   space_held_d = ~is_brk;
          8'h2D:   r_held_d     = ~is_brk;
          default: ;
        endcase
      end
    end

`ifdef HOST_KEYS_SOCD_EN
    // With both arrows held only the most recently pressed one is reported.
    left_out_d  = left_held_d & ~(right_held_d & last_dir_d);
    right_out_d = right_held_d & ~(left_held_d & ~last_dir_d);
`else
    left_out_d  = left_held_d;
    right_out_d = right_held_d;
`endif

    flags_changed = (left_held_d  != left_held_q)  |
                    (right_held_d != right_held_q) |
                    (up_held_d    != up_held_q)    |
                    (space_held_d != space_held_q) |
                    (r_held_d     != r_held_q);
  end

  // State, flags and registered outputs. The game-reset pulse fires only on
  // the rising edge of the R held flag, so typematic repeats are ignored,
  // and a fresh press during a pulse reloads the full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_CODE;
      to_cnt_q     <= '0;
      pulse_cnt_q  <= '0;
      left_held_q  <= 1'b0;
      right_held_q <= 1'b0;
      up_held_q    <= 1'b0;
      space_held_q <= 1'b0;
      r_held_q     <= 1'b0;
`ifdef HOST_KEYS_SOCD_EN
      last_dir_q   <= 1'b0;
`endif
      left         <= 1'b0;
      right        <= 1'b0;
      jump         <= 1'b0;
      game_reset   <= 1'b0;
      key_event    <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      left_held_q  <= left_held_d;
      right_held_q <= right_held_d;
      up_held_q    <= up_held_d;
      space_held_q <= space_held_d;
      r_held_q     <= r_held_d;
`ifdef HOST_KEYS_SOCD_EN
      last_dir_q   <= last_dir_d;
`endif
      left         <= left_out_d;
      right        <= right_out_d;
      jump         <= up_held_d | space_held_d;
      key_event    <= flags_changed;

      if (r_held_d && !r_held_q) begin
        game_reset  <= 1'b1;
        pulse_cnt_q <= PULSE_LAST;
      end else if (game_reset) begin
        if (pulse_cnt_q == '0) game_reset <= 1'b0;
        else                   pulse_cnt_q <= pulse_cnt_q - PW'(1);
      end
    end
  end

endmodule

// File: doc/host_key_decoder.md
Name: host_key_decoder

Overview:
- Sits between the PS/2 byte receiver and the host movement controller.
- Decodes the PS/2 set-2 make/break scancode stream into level-held movement commands: left, right and jump.
- Also produces a stretched game-reset pulse for the movement controller and game logic.
- The movement controller samples these outputs every clock, so all outputs are registered and glitch-free.

Parameters:
- TIMEOUT_CYCLES, 1_000_000, cycles allowed between a prefix byte (E0/F0) and its following byte before the sequence is abandoned.
- RESET_PULSE_CYCLES, 16, number of cycles game_reset stays high after an R-key make.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received scancode byte
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle
- rx_err  input  1  one-cycle strobe; receiver framing/parity error
- left  output  1  left key held
- right  output  1  right key held
- jump  output  1  jump key held
- game_reset  output  1  reset request pulse
- key_event  output  1  one-cycle strobe, high when any tracked key changes held state

Behaviour:
- Reset: rst_n low asynchronously clears all held flags, left/right/jump/game_reset/key_event = 0, state = WAIT_CODE, timeout counter = 0, pulse counter = 0.
- Tracked keys:
  - left arrow E0 6B
  - right arrow E0 74
  - up arrow E0 75 (jump)
  - space 29 (jump)
  - R 2D (reset)
- jump = up_held OR space_held.
- FSM states: WAIT_CODE, GOT_E0, GOT_F0, GOT_E0F0. Transitions occur only on rx_valid:
  - WAIT_CODE: E0 -> GOT_E0; F0 -> GOT_F0; any other byte = plain make, stay in WAIT_CODE.
  - GOT_E0: F0 -> GOT_E0F0; any other byte = extended make -> WAIT_CODE.
  - GOT_F0: any byte = plain break -> WAIT_CODE.
  - GOT_E0F0: any byte = extended break -> WAIT_CODE.
- Make sets the key's held flag; break clears it. Untracked codes (including FA, AA, EE) change nothing.
- A plain code that matches only an extended key (e.g. bare 6B) is not a match.
- Typematic repeats of a make are idempotent.
- Latency: outputs reflect the final byte one cycle after its rx_valid.
- key_event pulses for one cycle in that same cycle when any held flag changes value.
- Timeout counter:
  - Runs only in non-WAIT_CODE states and clears on every rx_valid.
  - On reaching TIMEOUT_CYCLES-1 without a byte, the FSM returns to WAIT_CODE and held flags are unchanged.
  - If rx_valid coincides with expiry, the byte is processed in the current state (byte wins).
- rx_err: FSM returns to WAIT_CODE and the timeout counter clears; held flags are unchanged. If rx_err and rx_valid are high together, rx_err wins and the byte is discarded.
- game_reset:
  - Triggered on the 0->1 transition of r_held only; typematic repeats do not retrigger.
  - Goes high the cycle after the R make and stays high exactly RESET_PULSE_CYCLES cycles.
  - A new trigger during an active pulse reloads the count.
- Both left and right held: both outputs are 1 (default build).
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Optional Feature:
- Macro HOST_KEYS_SOCD_EN: enables last-pressed-wins resolution.
- Defined:
  - A 1-bit last_dir register is updated on each left/right make (0 = left, 1 = right).
  - When both are held, only the output matching last_dir is 1.
  - When one is released, the other output reasserts in the next cycle.
  - last_dir resets to 0.
- Not defined: left/right are the raw held flags.

Test Plan:
- Bytes E0,6B -> left=1 one cycle after the 6B strobe, key_event one pulse; then E0,F0,6B -> left=0, key_event pulse.
- Byte 29 -> jump=1; then E0,75 -> jump stays 1; F0,29 -> jump stays 1; E0,F0,75 -> jump=0.
- Byte 2D repeated 5 times at 100-cycle spacing -> game_reset high exactly 16 cycles, once only; F0,2D then 2D -> second 16-cycle pulse.
- Byte E0 followed by idle for TIMEOUT_CYCLES (set to 50 in the bench), then 6B -> left stays 0 (plain 6B is not a match); E0,74 afterwards -> right=1.
- Byte F0, then rx_err, then 74 -> no break applied, right unchanged; rx_err and rx_valid together with 74 -> byte discarded.
- Make left, then make right (both held): default -> left=1 and right=1; with HOST_KEYS_SOCD_EN -> right=1, left=0; break right -> left=1 next cycle.
- rst_n pulsed low mid-sequence (after E0) with keys held -> all outputs 0 immediately; next byte 6B is treated as plain (no left).
